// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: time-shared AES SubBytes / InvSubBytes engine.
// A LANES-byte word is accepted, substituted UNITS bytes per cycle through
// arithmetic (GF(2^8) inverse + affine) S-box units, then held on a
// valid/ready output until the consumer takes it.
module sub_bytes_engine #(
  parameter int LANES = 16,
  parameter int UNITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data
);

  localparam int N   = (UNITS > 0) ? LANES / UNITS : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int DW  = 8 * LANES;
  localparam int AW  = (DW > 2) ? $clog2(DW) : 1;
  localparam int CHW = 8 * UNITS;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (UNITS < 1) begin : g_bad_units
    $error("sub_bytes_engine: UNITS must be at least 1");
  end else if ((UNITS > LANES) || ((LANES % UNITS) != 0)) begin : g_bad_split
    $error("sub_bytes_engine: UNITS must divide LANES and not exceed it");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   work_q, work_d;
  logic            mode_q;
  logic            accept;
  logic [AW-1:0]   base;
  logic [CHW-1:0]  chunk_in, chunk_out;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    return inv ? gf_inv(inv_affine(b)) : fwd_affine(gf_inv(b));
  endfunction

  // Control: next state and handshake outputs; in_ready never looks at in_valid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? S_BUSY : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign out_data = work_q;

  // Current chunk selection and the shared S-box units.
  assign base     = AW'(int'(cnt_q) * CHW);
  assign chunk_in = work_q[base +: CHW];

  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    assign chunk_out[8*u +: 8] = sbox(chunk_in[8*u +: 8], mode_q);
  end

  // Working register update: load on accept, in-place chunk write-back while busy.
  always_comb begin
    work_d = work_q;
    if (accept) begin
      work_d = in_data;
    end else if (state_q == S_BUSY) begin
      work_d[base +: CHW] = chunk_out;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Working register, mode latch and chunk counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      if (accept) begin
        mode_q <= in_inv;
        cnt_q  <= '0;
      end else if ((state_q == S_BUSY) && (cnt_q != LAST)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Testbench for sub_bytes_engine: directed vector table on the default
// (16,4) configuration, handshake corner sequences, and a 256-value
// forward/inverse round trip on the (16,1), (16,4) and (16,16) configurations.
module tb_sub_bytes_engine;

  localparam int NB [3] = '{16, 4, 1};

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef struct {
    logic [127:0] data;
    logic         inv;
    logic [127:0] exp;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(16), .UNITS(1)) u_dut_u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
  );

  sub_bytes_engine #(.LANES(16), .UNITS(4)) u_dut_u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  sub_bytes_engine #(.LANES(16), .UNITS(16)) u_dut_u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_inv(in_inv[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [127:0] d, input logic inv,
                         input logic [127:0] e, input string nm);
    vecs[i].data = d;
    vecs[i].inv  = inv;
    vecs[i].exp  = e;
    vecs[i].name = nm;
  endtask

  // Count edges from the accepting edge until out_valid is seen (bounded).
  task automatic wait_out(input int c, output int lat);
    lat = 0;
    while (!out_valid[c] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Send one word to instance c, wait for the result, then take it.
  task automatic run_word(input int c, input logic [127:0] d, input logic inv,
                          output logic [127:0] res, output int lat);
    int g;
    @(negedge clk);
    out_ready[c] = 1'b0;
    in_valid[c]  = 1'b1;
    in_data[c]   = d;
    in_inv[c]    = inv;
    g = 0;
    while (!in_ready[c] && g < 32) begin
      @(negedge clk);
      g++;
    end
    if (g >= 32) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: instance %0d never ready, expected ready", c);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[c] = 1'b0;
    wait_out(c, lat);
    res = out_data[c];
    out_ready[c] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[c] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, back, d, e;
    int           lat;

    in_valid  = '0;
    in_inv    = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;

    set_vec(0, '0, 1'b0, {16{8'h63}}, "fwd_zero");
    set_vec(1, {8'h16, {14{8'h63}}, 8'hed}, 1'b1, {8'hff, {14{8'h00}}, 8'h53}, "inv_mixed");
    set_vec(2, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
               128'h76abd7fe2b670130c56f6bf27b777c63, "fwd_ramp");
    set_vec(3, {16{8'hff}}, 1'b0, {16{8'h16}}, "fwd_ff");
    set_vec(4, {16{8'h16}}, 1'b1, {16{8'hff}}, "inv_16");
    set_vec(5, 128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1,
               128'h0f0e0d0c0b0a09080706050403020100, "inv_ramp");

    // Reset with a word offered: nothing may be accepted.
    rst_n       = 1'b0;
    in_valid[1] = 1'b1;
    in_data[1]  = {16{8'ha5}};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid[1]), 128'd0);
    chk("rst_out_data",  out_data[1], '0);
    chk("rst_in_ready",  128'(in_ready[1]), 128'd1);
    chk("rst_out_valid_all", 128'(out_valid), 128'd0);
    in_valid[1] = 1'b0;
    in_data[1]  = '0;
    rst_n       = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready[1]), 128'd1);

    // Directed vector table on the default configuration.
    for (int v = 0; v < 6; v++) begin
      run_word(1, vecs[v].data, vecs[v].inv, res, lat);
      chk({vecs[v].name, "_latency"}, 128'(lat), 128'd4);
      chk({vecs[v].name, "_data"}, res, vecs[v].exp);
    end

    // Backpressure for 10 cycles, then back-to-back accept on release.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = '0;
    in_inv[1]   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data[1]  = {16{8'h53}};
    wait_out(1, lat);
    chk("bp_first_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_data",     out_data[1], {16{8'h63}});
      chk("bp_hold_in_ready", 128'(in_ready[1]), 128'd0);
      chk("bp_hold_valid",    128'(out_valid[1]), 128'd1);
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(in_ready[1]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b0;
    chk("b2b_busy_no_valid", 128'(out_valid[1]), 128'd0);
    wait_out(1, lat);
    chk("b2b_latency", 128'(lat), 128'd4);
    chk("b2b_data", out_data[1], {16{8'hed}});
    out_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[1] = 1'b0;

    // Reset asserted after two of four beats.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = {16{8'hff}};
    in_inv[1]   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid[1]), 128'd0);
    chk("midrst_out_data",  out_data[1], '0);
    chk("midrst_in_ready",  128'(in_ready[1]), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(1, {16{8'h53}}, 1'b0, res, lat);
    chk("midrst_after_latency", 128'(lat), 128'd4);
    chk("midrst_after_data", res, {16{8'hed}});

    // Exhaustive forward then inverse round trip on all three configurations.
    for (int c = 0; c < 3; c++) begin
      for (int w = 0; w < 16; w++) begin
        for (int i = 0; i < 16; i++) begin
          d[8*i +: 8] = 8'(w * 16 + i);
          e[8*i +: 8] = SBOX[w * 16 + i];
        end
        run_word(c, d, 1'b0, res, lat);
        chk($sformatf("rt_fwd_c%0d_w%0d", c, w), res, e);
        chk($sformatf("rt_lat_c%0d_w%0d", c, w), 128'(lat), 128'(NB[c]));
        run_word(c, res, 1'b1, back, lat);
        chk($sformatf("rt_inv_c%0d_w%0d", c, w), back, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
